// File: rtl/bs_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : serial FSM states (IDLE/SHIFT/DONE)
//   BS_WIDTH  : default operand width
//   cnt_width : bit-counter width able to hold 0..w without wrapping
package bs_arith_pkg;

  localparam int unsigned BS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bs_sub_4bit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
//   in_valid/in_ready   : operand handshake (a, b)
//   out_valid/out_ready : result handshake (diff, borrow[, ovf])
// Optional: BS_SUB_OVF_EN adds the signed-overflow flag ovf.
interface bs_sub_4bit_if
  import bs_arith_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef BS_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum_c         : sum bit (combinational)
//   o_cout_c        : carry out (combinational)
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum_c,
  output logic o_cout_c
);

  assign o_sum_c  = i_a ^ i_b ^ i_cin;
  assign o_cout_c = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/bs_sub_4bit.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock through a single full adder (a + ~b + 1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bs_sub_4bit_if.slave (operand in, result out)
// Optional: BS_SUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module bs_sub_4bit
  import bs_arith_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  bs_sub_4bit_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_borrow;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_b_inv;
  logic             w_sum;
  logic             w_cout;

  // Next-state and per-edge control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Subtract as a + ~b with carry-in 1 seeded at capture
  assign w_b_inv = ~r_b[0];

  full_adder u_fa (
    .i_a      (r_a[0]),
    .i_b      (w_b_inv),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  // Operand shifters, result shifter (fills from MSB side), carry and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_cnt   <= '0;
      r_carry <= 1'b1;
    end else if (w_shift) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_diff  <= {w_sum, r_diff[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      // No carry out of the top bit means the subtraction borrowed
      if (w_last) begin
        r_borrow <= ~w_cout;
      end
    end
  end

`ifdef BS_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow: operand signs differ and result sign differs from a
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (w_sum ^ r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;

endmodule
